// File: rtl/mem_boot_loader_if.sv
// Byte-stream input and memory write port bundle for mem_boot_loader.
// master = stream source / memory side, slave = the loader itself.
interface mem_boot_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic              dmem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  dmem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output dmem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/mem_boot_loader.sv
// Framed byte-stream loader for IMEM/DMEM; holds the core in reset until DONE.
// Optional per-frame checksum byte enabled by defining BOOT_CHECKSUM_EN.
module mem_boot_loader #(
    parameter int          ADDR_W   = 10,
    parameter logic [7:0]  DONE_CMD = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    mem_boot_loader_if.slave bus,
    output logic             core_reset,
    output logic             done,
    output logic             error
);
    localparam logic [3:0] S_CMD   = 4'd0;
    localparam logic [3:0] S_ADDR0 = 4'd1;
    localparam logic [3:0] S_ADDR1 = 4'd2;
    localparam logic [3:0] S_CNT0  = 4'd3;
    localparam logic [3:0] S_CNT1  = 4'd4;
    localparam logic [3:0] S_DATA  = 4'd5;
    localparam logic [3:0] S_DONE  = 4'd7;
    localparam logic [3:0] S_ERR   = 4'd8;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [3:0] S_CSUM      = 4'd6;
    localparam logic [3:0] S_FRAME_END = S_CSUM;
`else
    localparam logic [3:0] S_FRAME_END = S_CMD;
`endif

    // One past the last legal word address, in the 17-bit range-check domain
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    logic [3:0]        state_reg, state_next;
    logic              in_ready_reg;
    logic              target_dmem_reg;
    logic [15:0]       addr_reg;
    logic [15:0]       cnt_reg;
    logic [1:0]        byte_idx_reg;
    logic              imem_we_reg;
    logic              dmem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic              core_reset_reg;
    logic              done_reg;
    logic              error_reg;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum_reg;
`endif

    logic              accept;
    logic              word_strobe;
    logic [15:0]       cnt_full;
    logic [16:0]       range_end;
    logic              range_bad;
    logic [23:0]       partial_word;

    assign accept      = bus.in_valid & in_ready_reg;
    assign word_strobe = accept && (state_reg == S_DATA) && (byte_idx_reg == 2'd3);
    assign cnt_full    = {bus.in_data, cnt_reg[7:0]};
    assign range_end   = {1'b0, addr_reg} + {1'b0, cnt_full};
    assign range_bad   = (range_end > DEPTH) || ({1'b0, addr_reg} >= DEPTH);

    // Bytes 0..2 of the word in flight; byte 3 is taken straight off the bus
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [7:0] lane_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                lane_reg <= '0;
            end else if (accept && (state_reg == S_DATA) && (byte_idx_reg == 2'(gi))) begin
                lane_reg <= bus.in_data;
            end
        end

        assign partial_word[gi*8 +: 8] = lane_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_CMD: begin
                if (accept) begin
                    if (bus.in_data == 8'h01 || bus.in_data == 8'h02) begin
                        state_next = S_ADDR0;
                    end else if (bus.in_data == DONE_CMD) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ERR;
                    end
                end
            end
            S_ADDR0: if (accept) state_next = S_ADDR1;
            S_ADDR1: if (accept) state_next = S_CNT0;
            S_CNT0:  if (accept) state_next = S_CNT1;
            S_CNT1: begin
                if (accept) begin
                    if (range_bad) begin
                        state_next = S_ERR;
                    end else if (cnt_full == 16'd0) begin
                        state_next = S_FRAME_END;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_strobe && (cnt_reg == 16'd1)) begin
                    state_next = S_FRAME_END;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_next = (bus.in_data == csum_reg) ? S_CMD : S_ERR;
                end
            end
`endif
            default: state_next = state_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_CMD;
            in_ready_reg    <= 1'b0;
            target_dmem_reg <= 1'b0;
            addr_reg        <= '0;
            cnt_reg         <= '0;
            byte_idx_reg    <= '0;
            imem_we_reg     <= 1'b0;
            dmem_we_reg     <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            core_reset_reg  <= 1'b1;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            in_ready_reg   <= (state_next != S_DONE) && (state_next != S_ERR);
            imem_we_reg    <= word_strobe & ~target_dmem_reg;
            dmem_we_reg    <= word_strobe & target_dmem_reg;
            done_reg       <= done_reg | (state_next == S_DONE);
            error_reg      <= error_reg | (state_next == S_ERR);
            core_reset_reg <= core_reset_reg & (state_next != S_DONE);

            if (accept) begin
                case (state_reg)
                    S_CMD: begin
                        target_dmem_reg <= (bus.in_data == 8'h02);
                        byte_idx_reg    <= 2'd0;
                    end
                    S_ADDR0: addr_reg[7:0]  <= bus.in_data;
                    S_ADDR1: addr_reg[15:8] <= bus.in_data;
                    S_CNT0:  cnt_reg[7:0]   <= bus.in_data;
                    S_CNT1:  cnt_reg[15:8]  <= bus.in_data;
                    S_DATA: begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (word_strobe) begin
                            mem_addr_reg  <= addr_reg[ADDR_W-1:0];
                            mem_wdata_reg <= {bus.in_data, partial_word};
                            addr_reg      <= addr_reg + 16'd1;
                            cnt_reg       <= cnt_reg - 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running sum restarts at each command byte so every frame is checked alone
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_reg <= '0;
        end else if (accept && state_reg == S_CMD) begin
            csum_reg <= '0;
        end else if (accept && state_reg == S_DATA) begin
            csum_reg <= csum_reg + bus.in_data;
        end
    end
`endif

    assign bus.in_ready  = in_ready_reg;
    assign bus.imem_we   = imem_we_reg;
    assign bus.dmem_we   = dmem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign core_reset    = core_reset_reg;
    assign done          = done_reg;
    assign error         = error_reg;
endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader: frame loads, DONE, errors, gaps, resets.
// Frames get a trailing checksum byte when BOOT_CHECKSUM_EN is defined.
module tb_mem_boot_loader;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic core_reset, done, error;

    mem_boot_loader_if #(.ADDR_W(AW)) bus ();

    mem_boot_loader #(.ADDR_W(AW), .DONE_CMD(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dm;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t        wr_q[$];
    int         checks = 0;
    int         errors = 0;
    int         overlap = 0;
    int         gap_cycles = 0;
    logic [7:0] tb_csum = 8'h00;

    always @(negedge clk) begin
        if (bus.imem_we && bus.dmem_we) overlap++;
        if (bus.imem_we || bus.dmem_we) begin
            wr_q.push_back('{bus.dmem_we, bus.mem_addr, bus.mem_wdata});
            $display("write %s addr 0x%03h data 0x%08h",
                     bus.dmem_we ? "dmem" : "imem", bus.mem_addr, bus.mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic dm,
                            input logic [AW-1:0] a, input logic [31:0] d);
        if (idx < wr_q.size()) begin
            check({tag, "_mem"}, 32'(wr_q[idx].dm), 32'(dm));
            check({tag, "_addr"}, 32'(wr_q[idx].a), 32'(a));
            check({tag, "_data"}, wr_q[idx].d, d);
        end else begin
            check({tag, "_missing"}, 32'(wr_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && w < 16) begin
            @(negedge clk);
            w++;
        end
        if (w >= 16) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            repeat (gap_cycles) @(posedge clk);
        end
    endtask

    task automatic poke_byte(input logic [7:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] c);
        send_byte(cmd);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(c[7:0]);
        send_byte(c[15:8]);
        tb_csum = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            tb_csum = tb_csum + w[8*i +: 8];
        end
    endtask

    task automatic end_frame();
`ifdef BOOT_CHECKSUM_EN
        send_byte(tb_csum);
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        check("rst_release_ready_lo", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("rst_release_ready_hi", 32'(bus.in_ready), 32'd1);

        // IMEM load of two words
        wr_q.delete();
        send_hdr(8'h01, 16'h0000, 16'h0002);
        send_word(32'h00100513);
        send_word(32'h00200593);
        end_frame();
        check("imem_count", 32'(wr_q.size()), 32'd2);
        check_wr("imem_w0", 0, 1'b0, 10'h000, 32'h00100513);
        check_wr("imem_w1", 1, 1'b0, 10'h001, 32'h00200593);
        check("imem_error", 32'(error), 32'd0);

        // DMEM load, strobe timing, then DONE
        wr_q.delete();
        send_hdr(8'h02, 16'h0010, 16'h0001);
        send_word(32'hDEADBEEF);
        check("dmem_we_pulse", 32'(bus.dmem_we), 32'd1);
        check("dmem_imem_quiet", 32'(bus.imem_we), 32'd0);
        check("dmem_addr", 32'(bus.mem_addr), 32'h010);
        check("dmem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        @(posedge clk);
        #1 check("dmem_we_one_cycle", 32'(bus.dmem_we), 32'd0);
        end_frame();
        check("pre_done_done", 32'(done), 32'd0);
        check("pre_done_core_reset", 32'(core_reset), 32'd1);
        send_byte(8'hA5);
        check("done_done", 32'(done), 32'd1);
        check("done_core_reset", 32'(core_reset), 32'd0);
        check("done_in_ready", 32'(bus.in_ready), 32'd0);
        check("done_error", 32'(error), 32'd0);
        poke_byte(8'h01);
        poke_byte(8'h00);
        check("done_mem_addr_hold", 32'(bus.mem_addr), 32'h010);
        check("done_count", 32'(wr_q.size()), 32'd1);
        check_wr("dmem_w0", 0, 1'b1, 10'h010, 32'hDEADBEEF);

        // Reset after DONE re-asserts core reset; then a bad command
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check("rst_after_done_core_reset", 32'(core_reset), 32'd1);
        check("rst_after_done_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wr_q.delete();
        send_byte(8'h7E);
        check("badcmd_error", 32'(error), 32'd1);
        check("badcmd_core_reset", 32'(core_reset), 32'd1);
        check("badcmd_in_ready", 32'(bus.in_ready), 32'd0);
        poke_byte(8'h01); poke_byte(8'h00); poke_byte(8'h00); poke_byte(8'h01);
        poke_byte(8'h00); poke_byte(8'h11); poke_byte(8'h22); poke_byte(8'h33);
        poke_byte(8'h44); poke_byte(8'hA5);
        repeat (2) @(negedge clk);
        check("badcmd_no_writes", 32'(wr_q.size()), 32'd0);
        check("badcmd_no_done", 32'(done), 32'd0);

        // Zero-count frame, top-of-memory boundary, then range overflow
        do_reset();
        wr_q.delete();
        send_hdr(8'h01, 16'h0005, 16'h0000);
        end_frame();
        check("cnt0_error", 32'(error), 32'd0);
        check("cnt0_in_ready", 32'(bus.in_ready), 32'd1);
        check("cnt0_no_writes", 32'(wr_q.size()), 32'd0);
        send_hdr(8'h01, 16'h03FE, 16'h0002);
        send_word(32'h44332211);
        send_word(32'h88776655);
        end_frame();
        check("edge_error", 32'(error), 32'd0);
        check_wr("edge_w0", 0, 1'b0, 10'h3FE, 32'h44332211);
        check_wr("edge_w1", 1, 1'b0, 10'h3FF, 32'h88776655);
        send_hdr(8'h01, 16'h03FF, 16'h0002);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_core_reset", 32'(core_reset), 32'd1);
        poke_byte(8'h11); poke_byte(8'h22); poke_byte(8'h33); poke_byte(8'h44);
        repeat (2) @(negedge clk);
        check("ovf_no_new_writes", 32'(wr_q.size()), 32'd2);

        // Gapped stream gives identical writes
        do_reset();
        wr_q.delete();
        gap_cycles = 1;
        send_hdr(8'h01, 16'h0000, 16'h0002);
        send_word(32'h00100513);
        send_word(32'h00200593);
        end_frame();
        gap_cycles = 0;
        check("gap_count", 32'(wr_q.size()), 32'd2);
        check_wr("gap_w0", 0, 1'b0, 10'h000, 32'h00100513);
        check_wr("gap_w1", 1, 1'b0, 10'h001, 32'h00200593);

        // Reset after two of four data bytes, then a fresh frame
        wr_q.delete();
        send_hdr(8'h02, 16'h0020, 16'h0001);
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_reset();
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_imem_we", 32'(bus.imem_we), 32'd0);
        check("midrst_dmem_we", 32'(bus.dmem_we), 32'd0);
        check("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("midrst_mem_wdata", bus.mem_wdata, 32'd0);
        check("midrst_core_reset", 32'(core_reset), 32'd1);
        check("midrst_error", 32'(error), 32'd0);
        check("midrst_no_writes", 32'(wr_q.size()), 32'd0);
        send_hdr(8'h02, 16'h0020, 16'h0001);
        send_word(32'h04030201);
        end_frame();
        check("fresh_count", 32'(wr_q.size()), 32'd1);
        check_wr("fresh_w0", 0, 1'b1, 10'h020, 32'h04030201);

`ifdef BOOT_CHECKSUM_EN
        // Checksum good, then bad checksum blocks release
        do_reset();
        wr_q.delete();
        send_hdr(8'h01, 16'h0000, 16'h0001);
        send_word(32'h04030201);
        send_byte(8'h0A);
        repeat (2) @(negedge clk);
        check("csum_ok_error", 32'(error), 32'd0);
        check_wr("csum_ok_w0", 0, 1'b0, 10'h000, 32'h04030201);
        send_hdr(8'h01, 16'h0000, 16'h0001);
        send_word(32'h04030201);
        send_byte(8'h0B);
        check("csum_bad_error", 32'(error), 32'd1);
        check_wr("csum_bad_w0", 1, 1'b0, 10'h000, 32'h04030201);
        poke_byte(8'hA5);
        repeat (2) @(negedge clk);
        check("csum_bad_core_reset", 32'(core_reset), 32'd1);
        check("csum_bad_done", 32'(done), 32'd0);
`endif

        check("we_never_overlap", 32'(overlap), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
